mouse_master_sm: RTL

MOUSE_MASTER_SM -- requirements
Module: mouse_master_sm

---
 rtl/mouse_pkg.sv | 15 +
 rtl/mouse_master_sm_if.sv | 23 ++
 rtl/mouse_timeout_counter.sv | 18 +
 rtl/mouse_master_sm.sv | 76 +++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// mouse_pkg: FSM state enum, PS/2 command/response bytes and the expected-response lookup
package mouse_pkg;
  typedef enum logic [3:0] {
    S_INIT, S_SEND_FF, S_WAIT_FF_SENT, S_WAIT_FA_1, S_WAIT_AA, S_WAIT_ID, S_SEND_F4,
    S_WAIT_F4_SENT, S_WAIT_FA_2, S_RX_B1, S_RX_B2, S_RX_B3, S_PUBLISH
  } state_e;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;
  function automatic logic [7:0] expected_rsp(state_e s);
    return (s == S_WAIT_AA) ? RSP_BAT_OK : (s == S_WAIT_ID) ? RSP_ID : RSP_ACK;
  endfunction
endpackage

// File: rtl/mouse_master_sm_if.sv
// mouse_master_sm_if: transmitter/receiver handshake and packet outputs; master = FSM side, slave = PHY/consumer side
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic       INIT_DONE;
  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, INIT_DONE,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT, INIT_DONE,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
endinterface

// File: rtl/mouse_timeout_counter.sv
// mouse_timeout_counter: saturating dwell timer (clk, rst, clear, enable in; expired out when count hits LIMIT-1 while enabled)
module mouse_timeout_counter #(
  parameter int unsigned LIMIT = 5000000,
  parameter int unsigned W     = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rst || clear) count <= '0;
    else if (enable && count != LAST) count <= count + 1'b1;
  assign expired = enable && count == LAST;
endmodule

// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 mouse init (FF/FA/AA/00, F4/FA) and 3-byte packet streaming; CLK, RESET, bus (master modport)
module mouse_master_sm
  import mouse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned TIMER_W        = 23
) (
  input  logic              CLK,
  input  logic              RESET,
  mouse_master_sm_if.master bus
);
  state_e     state, state_n;
  logic [7:0] byte_q, b1_q, b2_q, status_q, dx_q, dy_q;
  logic       expired, clean, rsp_ok, timed;
  assign clean  = bus.BYTE_ERROR_CODE == 2'b00;
  assign rsp_ok = clean && bus.BYTE_READ == expected_rsp(state);
  assign timed  = state inside {S_WAIT_FF_SENT, S_WAIT_FA_1, S_WAIT_AA, S_WAIT_ID, S_WAIT_F4_SENT,
                                S_WAIT_FA_2, S_RX_B2, S_RX_B3};
  always_comb begin
    state_n = state;
    case (state)
      S_INIT:         state_n = S_SEND_FF;
      S_SEND_FF:      state_n = S_WAIT_FF_SENT;
      S_WAIT_FF_SENT: state_n = bus.BYTE_SENT ? S_WAIT_FA_1 : expired ? S_SEND_FF : state;
      S_WAIT_FA_1:    state_n = bus.BYTE_READY ? (rsp_ok ? S_WAIT_AA : S_SEND_FF) : expired ? S_SEND_FF : state;
      S_WAIT_AA:      state_n = bus.BYTE_READY ? (rsp_ok ? S_WAIT_ID : S_SEND_FF) : expired ? S_SEND_FF : state;
      S_WAIT_ID:      state_n = bus.BYTE_READY ? (rsp_ok ? S_SEND_F4 : S_SEND_FF) : expired ? S_SEND_FF : state;
      S_SEND_F4:      state_n = S_WAIT_F4_SENT;
      S_WAIT_F4_SENT: state_n = bus.BYTE_SENT ? S_WAIT_FA_2 : expired ? S_SEND_FF : state;
      S_WAIT_FA_2:    state_n = bus.BYTE_READY ? (rsp_ok ? S_RX_B1 : S_SEND_FF) : expired ? S_SEND_FF : state;
      S_RX_B1:        state_n = (bus.BYTE_READY && clean && bus.BYTE_READ[3]) ? S_RX_B2 : state;
      S_RX_B2:        state_n = bus.BYTE_READY ? (clean ? S_RX_B3 : S_RX_B1) : expired ? S_RX_B1 : state;
      S_RX_B3:        state_n = bus.BYTE_READY ? (clean ? S_PUBLISH : S_RX_B1) : expired ? S_RX_B1 : state;
      S_PUBLISH:      state_n = S_RX_B1;
      default:        state_n = S_INIT;
    endcase
  end
  mouse_timeout_counter #(.LIMIT(TIMEOUT_CYCLES), .W(TIMER_W)) u_timer (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (state_n != state),
    .enable  (timed),
    .expired (expired)
  );
  // The packet registers load on the edge into PUBLISH so they are already valid
  // during the SEND_INTERRUPT cycle; byte 3 is taken straight from the receiver.
  always_ff @(posedge CLK)
    if (RESET) begin
      state    <= S_INIT;
      byte_q   <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      status_q <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
    end else begin
      state  <= state_n;
      byte_q <= (state_n == S_SEND_FF) ? CMD_RESET : (state_n == S_SEND_F4) ? CMD_ENABLE : byte_q;
      if (state == S_RX_B1 && state_n == S_RX_B2) b1_q <= bus.BYTE_READ;
      if (state == S_RX_B2 && state_n == S_RX_B3) b2_q <= bus.BYTE_READ;
      if (state == S_RX_B3 && state_n == S_PUBLISH) begin
        status_q <= b1_q;
        dx_q     <= b2_q;
        dy_q     <= bus.BYTE_READ;
      end
    end
  assign bus.SEND_BYTE      = state == S_SEND_FF || state == S_SEND_F4;
  assign bus.BYTE_TO_SEND   = byte_q;
  assign bus.READ_ENABLE    = state inside {S_WAIT_FA_1, S_WAIT_AA, S_WAIT_ID, S_WAIT_FA_2,
                                            S_RX_B1, S_RX_B2, S_RX_B3, S_PUBLISH};
  assign bus.INIT_DONE      = state inside {S_RX_B1, S_RX_B2, S_RX_B3, S_PUBLISH};
  assign bus.SEND_INTERRUPT = state == S_PUBLISH;
  assign bus.MOUSE_STATUS   = status_q;
  assign bus.MOUSE_DX       = dx_q;
  assign bus.MOUSE_DY       = dy_q;
endmodule
